// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg
// Shared definitions for the HPS PIO command bridge:
//   - bit positions inside the 4-bit status flag vector
//   - command FSM state encoding
//   - data word reported when a command is forced to complete by the watchdog
package pio_cmd_pkg;

    localparam int FLG_DONE = 0;
    localparam int FLG_BUSY = 1;
    localparam int FLG_ERR  = 2;
    localparam int FLG_FULL = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } pio_state_e;

    // Wide enough for any practical DATA_W; users slice the low bits.
    localparam logic [63:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/pio_cmd_fifo.sv
// pio_cmd_fifo
// Small synchronous FIFO holding instructions waiting to be issued.
// Simultaneous push and pop is supported in every state, including full:
// the head is read out while the new word is written behind it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     write request and data (ignored when full without pop)
//   pop               read request (ignored when empty)
//   rd_data           current head word (valid while !empty)
//   full, empty       occupancy status
//   count             number of stored words (0..DEPTH)
module pio_cmd_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pio_cmd_bridge.sv
// pio_cmd_bridge
// Bridges the HPS lightweight-bridge PIOs (instruct/enable/data_out/flags)
// to a coprocessor valid/ready command port. Each rising edge of the
// synchronised enable strobe queues one instruction; queued instructions
// are issued one at a time and each result word is returned to the HPS.
// Optional feature macro: PIO_TIMEOUT_EN (watchdog forcing completion of a
// command whose response never arrives).
// Ports:
//   clk_clk, reset_reset_n   clock, asynchronous active-low reset
//   pio_instruct_export      instruction word from HPS
//   pio_enable_export        HPS submit strobe (rising edge = submit)
//   pio_data_out_export      last result data
//   pio_flags_export         {full, error, busy, done}
//   cmd_valid/cmd_ready/cmd_instr   command handshake to coprocessor
//   rsp_valid/rsp_data/rsp_err      one-cycle result from coprocessor
module pio_cmd_bridge
    import pio_cmd_pkg::*;
#(
    parameter int INSTR_W     = 29,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [INSTR_W-1:0] pio_instruct_export,
    input  logic               pio_enable_export,
    output logic [DATA_W-1:0]  pio_data_out_export,
    output logic [3:0]         pio_flags_export,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [INSTR_W-1:0] cmd_instr,
    input  logic               rsp_valid,
    input  logic [DATA_W-1:0]  rsp_data,
    input  logic               rsp_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    // ------------------------------------------------------------------
    // Enable synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic en_sync;
    logic en_prev_reg;
    logic rise;

    generate
        if (SYNC_STAGES == 0) begin : g_sync_bypass
            assign en_sync = pio_enable_export;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg[0] <= pio_enable_export;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_reg[i] <= sync_reg[i-1];
                    end
                end
            end
            assign en_sync = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            en_prev_reg <= 1'b0;
        end else begin
            en_prev_reg <= en_sync;
        end
    end

    assign rise = en_sync && !en_prev_reg;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    pio_state_e          state_reg, state_next;
    logic [INSTR_W-1:0]  fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       count_after;
    logic                pop;
    logic                push_ok;
    logic                drop;

    // The head is consumed only from IDLE; a full FIFO can still take a
    // new word in the same cycle the head leaves.
    assign pop         = (state_reg == IDLE) && !fifo_empty;
    assign push_ok     = rise && (!fifo_full || pop);
    assign drop        = rise && !push_ok;
    assign count_after = fifo_count + CW'(push_ok) - CW'(pop);

    pio_cmd_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (push_ok),
        .wr_data (pio_instruct_export),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ------------------------------------------------------------------
    // Command FSM and result/status registers
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] cmd_reg, cmd_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic [3:0]         flags_reg, flags_next;
    logic               result;
    logic               result_err;

`ifdef PIO_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_reg, wd_next;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg <= IDLE;
            cmd_reg   <= '0;
            data_reg  <= '0;
            flags_reg <= '0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            data_reg  <= data_next;
            flags_reg <= flags_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        data_next  = data_reg;
        flags_next = flags_reg;
        result     = 1'b0;
        result_err = 1'b0;
`ifdef PIO_TIMEOUT_EN
        wd_next    = '0;
`endif

        case (state_reg)
            IDLE: begin
                if (pop) begin
                    cmd_next   = fifo_rd_data;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A real response on the watchdog's final cycle takes priority.
                if (rsp_valid) begin
                    data_next  = rsp_data;
                    result     = 1'b1;
                    result_err = rsp_err;
                    state_next = IDLE;
                end
`ifdef PIO_TIMEOUT_EN
                else if (wd_reg == WD_W'(TIMEOUT_CYC - 1)) begin
                    data_next  = TIMEOUT_DATA[DATA_W-1:0];
                    result     = 1'b1;
                    result_err = 1'b1;
                    state_next = IDLE;
                end else begin
                    wd_next = wd_reg + WD_W'(1);
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A result landing in the same cycle as a new submission leaves
        // done set: the completion is the more recent event.
        if (push_ok) begin
            flags_next[FLG_DONE] = 1'b0;
        end
        if (result) begin
            flags_next[FLG_DONE] = 1'b1;
        end

        // Error is sticky; a fresh submission to a fully idle bridge starts clean.
        if (push_ok && fifo_empty && (state_reg == IDLE)) begin
            flags_next[FLG_ERR] = 1'b0;
        end
        if (drop || (result && result_err)) begin
            flags_next[FLG_ERR] = 1'b1;
        end

        // Status reflects the state after this edge, not before it.
        flags_next[FLG_BUSY] = (count_after != '0) || (state_next != IDLE);
        flags_next[FLG_FULL] = (count_after == CW'(DEPTH));
    end

    assign cmd_valid           = (state_reg == ISSUE);
    assign cmd_instr           = cmd_reg;
    assign pio_data_out_export = data_reg;
    assign pio_flags_export    = flags_reg;

endmodule

// File: doc/pio_cmd_bridge.md
Name: pio_cmd_bridge

Overview:
- Parametrised successor to the fixed-width HPS PIO instruction/enable/data/flags handshake. Sits between the HPS lightweight-bridge PIOs (instruct, enable, data_out, flags) and the FPGA coprocessor.
- Synchronises the enable strobe and queues instructions in a FIFO. Issues them one at a time over a valid/ready command port.
- Returns each result word and a status flag vector back to the HPS PIOs.

Parameters:
- INSTR_W, 29, instruction width (pio_instruct_export, cmd_instr).
- DATA_W, 8, result data width.
- DEPTH, 4, instruction FIFO depth; power of two, ≥2.
- SYNC_STAGES, 2, enable synchroniser flops; 0 = bypass.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with PIO_TIMEOUT_EN.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- pio_instruct_export  in  INSTR_W  instruction word from HPS PIO.
- pio_enable_export  in  1  HPS strobe; each rising edge submits one instruction.
- pio_data_out_export  out  DATA_W  last result data.
- pio_flags_export  out  4  status: [0] done, [1] busy, [2] error, [3] full.
- cmd_valid  out  1  command available to coprocessor.
- cmd_ready  in  1  coprocessor accepts command.
- cmd_instr  out  INSTR_W  command payload.
- rsp_valid  in  1  one-cycle result strobe.
- rsp_data  in  DATA_W  result data.
- rsp_err  in  1  coprocessor error for this result.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, FSM IDLE, synchroniser flops 0, watchdog 0.
- Enable path: SYNC_STAGES flops, then an edge register. A rise is one cycle with the sync output high and the previous value low. Level-high or falling edges never push.
- Push: on a rise, pio_instruct_export is written into the FIFO that cycle. HPS holds instruct stable from SYNC_STAGES+1 cycles before the enable rise until enable falls.
- Full: a rise while count==DEPTH is dropped and sets error (sticky). A push and a pop in the same cycle when full succeeds; count unchanged.
- FSM IDLE: when FIFO non-empty, pop the head into the cmd register and go to ISSUE.
- FSM ISSUE: cmd_valid=1 and cmd_instr stable until cmd_valid&&cmd_ready, then go to WAIT.
- FSM WAIT: on rsp_valid, register rsp_data into pio_data_out_export, set done, OR rsp_err into error, then go to IDLE.
- rsp_valid outside WAIT is ignored; no flag or data change.
- Latency (SYNC_STAGES=2, empty FIFO, FSM IDLE): cmd_valid rises at the 4th clock edge after enable is first sampled high. In general this is the (SYNC_STAGES+2)th edge.
- Result latency: pio_data_out_export and done update on the edge after rsp_valid.
- done: set by a result; cleared by the next accepted (non-dropped) rise.
- error: sticky; cleared only by reset, or by an accepted rise while FIFO empty and FSM IDLE.
- busy = FIFO non-empty OR FSM≠IDLE, registered.
- full = count==DEPTH, registered.
- Only one command is outstanding at a time. Instructions are issued in FIFO order.
- Reset mid-operation abandons any outstanding command. A rsp_valid arriving after reset release, with FSM IDLE, is ignored.

Optional Feature:
- Macro PIO_TIMEOUT_EN.
- When defined: a watchdog counter runs in WAIT and clears on leaving WAIT. On reaching TIMEOUT_CYC-1 without rsp_valid, the FSM forces completion:
  - pio_data_out_export = all-ones,
  - error=1, done=1,
  - FSM returns to IDLE.
- If rsp_valid arrives on the timeout cycle, the real response wins.
- When undefined: no counter is built; WAIT waits indefinitely. TIMEOUT_CYC is unused.

Decomposition:
- Package pio_cmd_pkg:
  - flag bit indices FLG_DONE=0, FLG_BUSY=1, FLG_ERR=2, FLG_FULL=3;
  - FSM enum {IDLE, ISSUE, WAIT};
  - timeout data constant (all-ones).
- One sub-module: pio_cmd_fifo. It is a synchronous FIFO parametrised by width/depth, with push/pop/full/empty/count outputs and correct simultaneous push+pop.
- Synchroniser and FSM stay in the top level.

Test Plan:
1. Basic command: instruct=29'h0ABCDEF, enable 0→1.
   - cmd_valid rises 4 edges later, cmd_instr=29'h0ABCDEF, busy=1.
   - Coprocessor: ready=1, then rsp_valid with data=8'h5A, err=0.
   - Expect data_out=8'h5A, flags=4'b0001.
2. Queue and order: 5 enable pulses with instructions 1..5 while cmd_ready=0 (DEPTH=4).
   - 1 is in the cmd register and 2–5 fill the FIFO. Flags: full=1, error=0.
   - Release ready and answer each; cmd_instr sequence must be 1,2,3,4,5. Final flags=4'b0001.
3. Overflow: 6 pulses while stalled.
   - Sixth is dropped and error=1.
   - error stays set after draining; the next rise with FIFO empty clears it.
4. Enable held high for 100 cycles → exactly one push. rsp_valid pulsed while IDLE → data_out and flags unchanged.
5. Reset asserted in WAIT with cmd outstanding.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - A late rsp_valid after release is ignored.
   - A new instruction proceeds normally.
6. With PIO_TIMEOUT_EN and TIMEOUT_CYC=16, command accepted with no response:
   - After 16 cycles in WAIT: data_out=8'hFF, flags=4'b0101.
   - Without the macro: still WAIT after 1000 cycles.
